rpn_stack_sequencer: RTL and testbench

Controller that sequences the 16-bit ALU datapath as a true RPN calculator with a small operand stack. It replaces the fixed load-A / load-B / load-Op sequencing. Operands are pushed with push_pulse. op_pulse pops the two top entries, drives them to the ALU with a start/done handshake, and pushes the result back. The block sits between the edge detectors (pulse inputs) and the ALU/display path, and supports one level of undo.

---
 rtl/rpn_stack_sequencer_pkg.sv | 33 +++
 rtl/rpn_stack_sequencer_if.sv | 23 ++
 rtl/rpn_stack_sequencer_operand_stack.sv | 55 +++++
 rtl/rpn_stack_sequencer.sv | 169 ++++++++++++++++
 tb/tb_rpn_stack_sequencer.sv | 295 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rpn_stack_sequencer_pkg.sv
// Shared types and constants for the RPN stack sequencer: FSM states,
// status codes, undo record kinds and ALU opcodes.
package rpn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    POP,
    START,
    WAIT,
    WRITEBACK,
    RESTORE,
    UNDO
  } state_t;

  typedef enum logic [1:0] {
    UK_NONE,
    UK_PUSH,
    UK_OP
  } undo_kind_t;

  localparam logic [2:0] ST_READY      = 3'd0;
  localparam logic [2:0] ST_BUSY       = 3'd1;
  localparam logic [2:0] ST_OVERFLOW   = 3'd2;
  localparam logic [2:0] ST_UNDERFLOW  = 3'd3;
  localparam logic [2:0] ST_TIMEOUT    = 3'd4;
  localparam logic [2:0] ST_UNDO_EMPTY = 3'd5;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_OR  = 2'd2;
  localparam logic [1:0] OP_AND = 2'd3;

endpackage

// File: rtl/rpn_stack_sequencer_if.sv
// ALU handshake bundle between the sequencer (master) and the ALU (slave).
interface rpn_stack_sequencer_if #(
  parameter int DATA_W = 16,
  parameter int OP_W   = 2
);
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic              alu_start;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        alu_flags;

  modport master (
    output alu_a, alu_b, alu_op, alu_start,
    input  alu_done, alu_result, alu_flags
  );

  modport slave (
    input  alu_a, alu_b, alu_op, alu_start,
    output alu_done, alu_result, alu_flags
  );
endinterface

// File: rtl/rpn_stack_sequencer_operand_stack.sv
// Operand register stack: push, pop one, pop two, re-grow two (entries are
// never cleared on pop, so a re-grow restores them), and replace-top.
// Depth saturates at 0 and DEPTH; out-of-range requests are ignored.
module operand_stack #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 16,
  localparam int CNT_W = $clog2(DEPTH) + 1,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_en,
  input  logic [DATA_W-1:0] push_data,
  input  logic              replace_en,
  input  logic [DATA_W-1:0] replace_data,
  input  logic              pop1_en,
  input  logic              pop2_en,
  input  logic              unpop2_en,
  output logic [CNT_W-1:0]  depth,
  output logic [DATA_W-1:0] top_value,
  output logic [DATA_W-1:0] second_value
);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);
  localparam logic [CNT_W-1:0] FULL    = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] FULL_M2 = CNT_W'(DEPTH - 2);

  logic [DATA_W-1:0] entry [DEPTH];
  logic [CNT_W-1:0]  depth_nxt;

  // Next depth; only one adjustment is requested per cycle except replace+push.
  always_comb begin
    depth_nxt = depth;
    if (pop2_en && depth >= TWO)            depth_nxt = depth - TWO;
    else if (unpop2_en && depth <= FULL_M2) depth_nxt = depth + TWO;
    else if (pop1_en && depth != '0)        depth_nxt = depth - ONE;
    else if (push_en && depth < FULL)       depth_nxt = depth + ONE;
  end

  // Entry writes and depth register.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      for (int i = 0; i < DEPTH; i++) entry[i] <= '0;
    end else begin
      if (replace_en && depth != '0) entry[IDX_W'(depth - ONE)] <= replace_data;
      if (push_en && depth < FULL)   entry[IDX_W'(depth)]       <= push_data;
      depth <= depth_nxt;
    end
  end

  assign top_value    = (depth != '0)  ? entry[IDX_W'(depth - ONE)] : '0;
  assign second_value = (depth >= TWO) ? entry[IDX_W'(depth - TWO)] : '0;

endmodule

// File: rtl/rpn_stack_sequencer.sv
// RPN calculator controller: accepts push/op/undo pulses in IDLE, pops two
// operands into the ALU with a start/done handshake, writes the result back,
// restores the operands on ALU timeout, and keeps a single-level undo record.
module rpn_stack_sequencer
  import rpn_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 16,
  parameter int OP_W    = 2,
  parameter int TIMEOUT = 15,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    DataIn,
  input  logic                 push_pulse,
  input  logic                 op_pulse,
  input  logic [OP_W-1:0]      op_code,
  input  logic                 undo_pulse,
  rpn_stack_sequencer_if.master alu,
  output logic [DATA_W-1:0]    top_value,
  output logic [CNT_W-1:0]     depth,
  output logic [4:0]           Flags,
  output logic [2:0]           Status,
  output logic                 busy
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  state_t            state;
  undo_kind_t        undo_kind;
  logic [DATA_W-1:0] undo_a, undo_b;
  logic [DATA_W-1:0] res_q;
  logic [4:0]        flags_q;
  logic [TW-1:0]     wait_cnt;

  logic              push_en, replace_en, pop1_en, pop2_en, unpop2_en;
  logic [DATA_W-1:0] push_data, replace_data, second_value;

  operand_stack #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_stack (
    .clk          (clk),
    .rst          (reset),
    .push_en      (push_en),
    .push_data    (push_data),
    .replace_en   (replace_en),
    .replace_data (replace_data),
    .pop1_en      (pop1_en),
    .pop2_en      (pop2_en),
    .unpop2_en    (unpop2_en),
    .depth        (depth),
    .top_value    (top_value),
    .second_value (second_value)
  );

  // Stack control decode from the current state and IDLE command priority.
  always_comb begin
    push_en      = 1'b0;
    push_data    = DataIn;
    replace_en   = 1'b0;
    replace_data = undo_a;
    pop1_en      = 1'b0;
    pop2_en      = 1'b0;
    unpop2_en    = 1'b0;
    case (state)
      IDLE:      push_en = push_pulse && !op_pulse && !undo_pulse;
      POP:       pop2_en = 1'b1;
      WRITEBACK: begin
        push_en   = 1'b1;
        push_data = res_q;
      end
      RESTORE:   unpop2_en = 1'b1;
      UNDO: begin
        if (undo_kind == UK_PUSH) pop1_en = 1'b1;
        if (undo_kind == UK_OP) begin
          replace_en = 1'b1;
          push_en    = 1'b1;
          push_data  = undo_b;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered ALU, status, flag and undo outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      Status        <= ST_READY;
      Flags         <= '0;
      alu.alu_a     <= '0;
      alu.alu_b     <= '0;
      alu.alu_op    <= '0;
      alu.alu_start <= 1'b0;
      undo_kind     <= UK_NONE;
      undo_a        <= '0;
      undo_b        <= '0;
      res_q         <= '0;
      flags_q       <= '0;
      wait_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (undo_pulse) begin
            if (undo_kind == UK_NONE) Status <= ST_UNDO_EMPTY;
            else begin
              Status <= ST_READY;
              state  <= UNDO;
            end
          end else if (op_pulse) begin
            if (depth < TWO) Status <= ST_UNDERFLOW;
            else begin
              Status     <= ST_BUSY;
              alu.alu_op <= op_code;
              state      <= POP;
            end
          end else if (push_pulse) begin
            if (depth == FULL) Status <= ST_OVERFLOW;
            else begin
              Status    <= ST_READY;
              undo_kind <= UK_PUSH;
            end
          end
        end
        POP: begin
          alu.alu_a     <= second_value;
          alu.alu_b     <= top_value;
          alu.alu_start <= 1'b1;
          state         <= START;
        end
        START: begin
          alu.alu_start <= 1'b0;
          wait_cnt      <= '0;
          state         <= WAIT;
        end
        WAIT: begin
          if (alu.alu_done) begin
            res_q   <= alu.alu_result;
            flags_q <= alu.alu_flags;
            state   <= WRITEBACK;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            Status <= ST_TIMEOUT;
            state  <= RESTORE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        WRITEBACK: begin
          Flags     <= flags_q;
          undo_kind <= UK_OP;
          undo_a    <= alu.alu_a;
          undo_b    <= alu.alu_b;
          Status    <= ST_READY;
          state     <= IDLE;
        end
        RESTORE: state <= IDLE;
        UNDO: begin
          if (undo_kind == UK_OP) Flags <= '0;
          undo_kind <= UK_NONE;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_rpn_stack_sequencer.sv
// Directed testbench for rpn_stack_sequencer with a small behavioural ALU.
module tb_rpn_stack_sequencer;
  import rpn_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] DataIn;
  logic        push_pulse, op_pulse, undo_pulse;
  logic [1:0]  op_code;
  logic [15:0] top_value;
  logic [2:0]  depth;
  logic [4:0]  Flags;
  logic [2:0]  Status;
  logic        busy;

  int checks = 0;
  int failures = 0;
  int start_cnt = 0;
  int alu_lat = 2;
  bit alu_mute = 1'b0;

  rpn_stack_sequencer_if #(.DATA_W(16), .OP_W(2)) alu_if ();

  rpn_stack_sequencer #(.DEPTH(4), .DATA_W(16), .OP_W(2), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .DataIn     (DataIn),
    .push_pulse (push_pulse),
    .op_pulse   (op_pulse),
    .op_code    (op_code),
    .undo_pulse (undo_pulse),
    .alu        (alu_if),
    .top_value  (top_value),
    .depth      (depth),
    .Flags      (Flags),
    .Status     (Status),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] alu_calc(input logic [15:0] a, input logic [15:0] b,
                                           input logic [1:0] op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      default: return a & b;
    endcase
  endfunction

  // Behavioural ALU: done alu_lat cycles after start, flags = {1,00,op}.
  initial begin : alu_model
    int cd;
    cd = 0;
    alu_if.alu_done   = 1'b0;
    alu_if.alu_result = '0;
    alu_if.alu_flags  = '0;
    forever begin
      @(posedge clk);
      #1;
      alu_if.alu_done = 1'b0;
      if (cd > 0) begin
        cd = cd - 1;
        if (cd == 0) begin
          alu_if.alu_done   = 1'b1;
          alu_if.alu_result = alu_calc(alu_if.alu_a, alu_if.alu_b, alu_if.alu_op);
          alu_if.alu_flags  = {1'b1, 2'b00, alu_if.alu_op};
        end
      end
      if (alu_if.alu_start === 1'b1) begin
        start_cnt++;
        if (!alu_mute) cd = alu_lat;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse_push(input logic [15:0] v);
    @(negedge clk);
    DataIn = v; push_pulse = 1'b1;
    @(negedge clk);
    push_pulse = 1'b0;
  endtask

  task automatic pulse_op(input logic [1:0] op);
    @(negedge clk);
    op_code = op; op_pulse = 1'b1;
    @(negedge clk);
    op_pulse = 1'b0;
  endtask

  task automatic pulse_undo();
    @(negedge clk);
    undo_pulse = 1'b1;
    @(negedge clk);
    undo_pulse = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int n, output bit ok);
    n = 0;
    while (busy === 1'b1 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (depth !== 3'd0) begin failures++; $display("FAIL reset_depth got=%0d exp=0", depth); end
    checks++; if (top_value !== 16'd0) begin failures++; $display("FAIL reset_top got=%0d exp=0", top_value); end
    checks++; if (Status !== ST_READY) begin failures++; $display("FAIL reset_status got=%0d exp=0", Status); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (Flags !== 5'd0) begin failures++; $display("FAIL reset_flags got=%0h exp=0", Flags); end
    checks++; if (alu_if.alu_start !== 1'b0 || alu_if.alu_a !== 16'd0 || alu_if.alu_b !== 16'd0)
      begin failures++; $display("FAIL reset_alu got=%0b/%0d/%0d exp=0/0/0", alu_if.alu_start, alu_if.alu_a, alu_if.alu_b); end
  endtask

  task automatic test_add();
    int s0, n;
    do_reset();
    pulse_push(16'd5);
    pulse_push(16'd3);
    s0 = start_cnt;
    pulse_op(OP_ADD);
    n = 1;
    while (top_value !== 16'd8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++; if (n !== 6) begin failures++; $display("FAIL add_latency got=%0d exp=6", n); end
    checks++; if (alu_if.alu_a !== 16'd5) begin failures++; $display("FAIL add_alu_a got=%0d exp=5", alu_if.alu_a); end
    checks++; if (alu_if.alu_b !== 16'd3) begin failures++; $display("FAIL add_alu_b got=%0d exp=3", alu_if.alu_b); end
    checks++; if (start_cnt - s0 !== 1) begin failures++; $display("FAIL add_starts got=%0d exp=1", start_cnt - s0); end
    checks++; if (top_value !== 16'd8) begin failures++; $display("FAIL add_top got=%0d exp=8", top_value); end
    checks++; if (depth !== 3'd1) begin failures++; $display("FAIL add_depth got=%0d exp=1", depth); end
    checks++; if (Status !== ST_READY) begin failures++; $display("FAIL add_status got=%0d exp=0", Status); end
    checks++; if (Flags !== 5'h10) begin failures++; $display("FAIL add_flags got=%0h exp=10", Flags); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL add_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_overflow_underflow();
    int s0;
    do_reset();
    pulse_push(16'd1);
    pulse_push(16'd2);
    pulse_push(16'd3);
    pulse_push(16'd4);
    checks++; if (Status !== ST_READY) begin failures++; $display("FAIL fill_status got=%0d exp=0", Status); end
    pulse_push(16'd9);
    @(negedge clk);
    checks++; if (Status !== ST_OVERFLOW) begin failures++; $display("FAIL ovf_status got=%0d exp=2", Status); end
    checks++; if (depth !== 3'd4) begin failures++; $display("FAIL ovf_depth got=%0d exp=4", depth); end
    checks++; if (top_value !== 16'd4) begin failures++; $display("FAIL ovf_top got=%0d exp=4", top_value); end
    do_reset();
    s0 = start_cnt;
    pulse_op(OP_ADD);
    @(negedge clk);
    @(negedge clk);
    checks++; if (Status !== ST_UNDERFLOW) begin failures++; $display("FAIL udf_status got=%0d exp=3", Status); end
    checks++; if (start_cnt - s0 !== 0) begin failures++; $display("FAIL udf_starts got=%0d exp=0", start_cnt - s0); end
    checks++; if (busy !== 1'b0 || depth !== 3'd0) begin failures++; $display("FAIL udf_state got=busy%0b/depth%0d exp=busy0/depth0", busy, depth); end
  endtask

  task automatic test_timeout();
    int n;
    bit ok;
    do_reset();
    alu_mute = 1'b1;
    pulse_push(16'd7);
    pulse_push(16'd2);
    pulse_op(OP_SUB);
    wait_idle(60, n, ok);
    alu_mute = 1'b0;
    checks++; if (!ok) begin failures++; $display("FAIL to_idle got=busy exp=idle"); end
    checks++; if (n !== 18) begin failures++; $display("FAIL to_busy_cycles got=%0d exp=18", n); end
    checks++; if (Status !== ST_TIMEOUT) begin failures++; $display("FAIL to_status got=%0d exp=4", Status); end
    checks++; if (depth !== 3'd2) begin failures++; $display("FAIL to_depth got=%0d exp=2", depth); end
    checks++; if (top_value !== 16'd2) begin failures++; $display("FAIL to_top got=%0d exp=2", top_value); end
    checks++; if (Flags !== 5'd0) begin failures++; $display("FAIL to_flags got=%0h exp=0", Flags); end
  endtask

  task automatic test_undo();
    int n;
    bit ok;
    do_reset();
    pulse_undo();
    @(negedge clk);
    checks++; if (Status !== ST_UNDO_EMPTY) begin failures++; $display("FAIL undo_rst_status got=%0d exp=5", Status); end
    pulse_push(16'd7);
    pulse_push(16'd2);
    pulse_op(OP_SUB);
    wait_idle(40, n, ok);
    checks++; if (!ok || top_value !== 16'd5 || depth !== 3'd1) begin failures++; $display("FAIL sub_result got=%0d/d%0d exp=5/d1", top_value, depth); end
    checks++; if (Flags !== 5'h11) begin failures++; $display("FAIL sub_flags got=%0h exp=11", Flags); end
    pulse_undo();
    wait_idle(10, n, ok);
    checks++; if (depth !== 3'd2) begin failures++; $display("FAIL undo_op_depth got=%0d exp=2", depth); end
    checks++; if (top_value !== 16'd2) begin failures++; $display("FAIL undo_op_top got=%0d exp=2", top_value); end
    checks++; if (Flags !== 5'd0) begin failures++; $display("FAIL undo_op_flags got=%0h exp=0", Flags); end
    pulse_undo();
    @(negedge clk);
    checks++; if (Status !== ST_UNDO_EMPTY) begin failures++; $display("FAIL undo2_status got=%0d exp=5", Status); end
    checks++; if (depth !== 3'd2) begin failures++; $display("FAIL undo2_depth got=%0d exp=2", depth); end
    pulse_op(OP_ADD);
    wait_idle(40, n, ok);
    checks++; if (alu_if.alu_a !== 16'd7) begin failures++; $display("FAIL undo_below got=%0d exp=7", alu_if.alu_a); end
    checks++; if (top_value !== 16'd9) begin failures++; $display("FAIL undo_readd got=%0d exp=9", top_value); end
    pulse_push(16'd6);
    pulse_undo();
    wait_idle(10, n, ok);
    checks++; if (depth !== 3'd1 || top_value !== 16'd9) begin failures++; $display("FAIL undo_push got=%0d/d%0d exp=9/d1", top_value, depth); end
    checks++; if (Status !== ST_READY) begin failures++; $display("FAIL undo_push_status got=%0d exp=0", Status); end
  endtask

  task automatic test_priority();
    int n, s0;
    bit ok;
    do_reset();
    alu_lat = 6;
    pulse_push(16'd10);
    pulse_push(16'd20);
    @(negedge clk);
    DataIn = 16'd99; push_pulse = 1'b1; op_code = OP_ADD; op_pulse = 1'b1;
    @(negedge clk);
    push_pulse = 1'b0; op_pulse = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_busy got=%0b exp=1", busy); end
    pulse_push(16'd55);
    wait_idle(40, n, ok);
    alu_lat = 2;
    checks++; if (!ok || depth !== 3'd1) begin failures++; $display("FAIL prio_depth got=%0d exp=1", depth); end
    checks++; if (top_value !== 16'd30) begin failures++; $display("FAIL prio_top got=%0d exp=30", top_value); end
    checks++; if (alu_if.alu_a !== 16'd10 || alu_if.alu_b !== 16'd20) begin failures++; $display("FAIL prio_ops got=%0d,%0d exp=10,20", alu_if.alu_a, alu_if.alu_b); end
    s0 = start_cnt;
    @(negedge clk);
    undo_pulse = 1'b1; op_pulse = 1'b1; op_code = OP_ADD;
    @(negedge clk);
    undo_pulse = 1'b0; op_pulse = 1'b0;
    wait_idle(40, n, ok);
    @(negedge clk);
    checks++; if (depth !== 3'd2 || top_value !== 16'd20) begin failures++; $display("FAIL prio_undo got=%0d/d%0d exp=20/d2", top_value, depth); end
    checks++; if (start_cnt - s0 !== 0) begin failures++; $display("FAIL prio_undo_starts got=%0d exp=0", start_cnt - s0); end
  endtask

  task automatic test_reset_mid_op();
    do_reset();
    alu_lat = 5;
    pulse_push(16'd1);
    pulse_push(16'd2);
    pulse_op(OP_ADD);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if (busy !== 1'b0 || depth !== 3'd0) begin failures++; $display("FAIL mid_reset got=busy%0b/d%0d exp=busy0/d0", busy, depth); end
    repeat (10) @(negedge clk);
    alu_lat = 2;
    checks++; if (depth !== 3'd0) begin failures++; $display("FAIL late_done_depth got=%0d exp=0", depth); end
    checks++; if (top_value !== 16'd0) begin failures++; $display("FAIL late_done_top got=%0d exp=0", top_value); end
    checks++; if (Status !== ST_READY || busy !== 1'b0) begin failures++; $display("FAIL late_done_status got=%0d/%0b exp=0/0", Status, busy); end
    checks++; if (Flags !== 5'd0) begin failures++; $display("FAIL late_done_flags got=%0h exp=0", Flags); end
  endtask

  initial begin
    reset = 1'b0; DataIn = '0; push_pulse = 1'b0; op_pulse = 1'b0;
    undo_pulse = 1'b0; op_code = '0;
    test_reset();
    test_add();
    test_overflow_underflow();
    test_timeout();
    test_undo();
    test_priority();
    test_reset_mid_op();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
